// File: rtl/tcp_stream_arb_if.sv
// AXI-Stream bundle for the stream arbiter: NUM_STREAMS flattened sources plus one merged sink.
// Latency: none, this is wiring only.
// Backpressure: s_axis_tready per source toward the producers, m_axis_tready from the DMA sink.
interface tcp_stream_arb_if #(
    parameter int NUM_STREAMS = 8,
    parameter int DATA_WIDTH  = 8,
    parameter int KEEP_WIDTH  = (DATA_WIDTH + 7) / 8,
    parameter int DEST_WIDTH  = 8,
    parameter int USER_WIDTH  = 1
);
    // Source side, stream i lives at [i*WIDTH +: WIDTH]
    logic [NUM_STREAMS*DATA_WIDTH-1:0] s_axis_tdata;
    logic [NUM_STREAMS*KEEP_WIDTH-1:0] s_axis_tkeep;
    logic [NUM_STREAMS-1:0]            s_axis_tvalid;
    logic [NUM_STREAMS-1:0]            s_axis_tready;
    logic [NUM_STREAMS-1:0]            s_axis_tlast;
    logic [NUM_STREAMS*USER_WIDTH-1:0] s_axis_tuser;

    // Merged side toward the s2m DMA
    logic [DATA_WIDTH-1:0]             m_axis_tdata;
    logic [KEEP_WIDTH-1:0]             m_axis_tkeep;
    logic                              m_axis_tvalid;
    logic                              m_axis_tready;
    logic                              m_axis_tlast;
    logic [DEST_WIDTH-1:0]             m_axis_tdest;
    logic [USER_WIDTH-1:0]             m_axis_tuser;

    // Arbiter view: consumes the sources, produces the merged stream.
    modport slave (
        input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
        output s_axis_tready,
        output m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tdest, m_axis_tuser,
        input  m_axis_tready
    );

    // Environment view: drives the sources, sinks the merged stream.
    modport master (
        output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
        input  s_axis_tready,
        input  m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tdest, m_axis_tuser,
        output m_axis_tready
    );
endinterface

// File: rtl/tcp_stream_arb.sv
// Packet-granular weighted round-robin merge of NUM_STREAMS AXI-Stream sources, tagging tdest with the source index.
// Latency: 1 bubble cycle per grant, then 1 cycle source-to-output at 1 beat/cycle.
// Backpressure: granted source tready = output register empty or draining; all others held off.
module tcp_stream_arb #(
    parameter int NUM_STREAMS  = 8,
    parameter int DATA_WIDTH   = 8,
    parameter int KEEP_WIDTH   = (DATA_WIDTH + 7) / 8,
    parameter int DEST_WIDTH   = 8,
    parameter int USER_WIDTH   = 1,
    parameter int WEIGHT_WIDTH = 4,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                                i_clk,
    input  logic                                i_rst_n,
    tcp_stream_arb_if.slave                     axis,
    input  logic [NUM_STREAMS-1:0]              i_enable,
    input  logic [NUM_STREAMS*WEIGHT_WIDTH-1:0] i_weight,
    input  logic [NUM_STREAMS-1:0]              i_cnt_clear,
    output logic [NUM_STREAMS*CNT_WIDTH-1:0]    o_pkt_count,
    output logic [$clog2(NUM_STREAMS)-1:0]      o_grant,
    output logic                                o_busy
);
    localparam int GW = $clog2(NUM_STREAMS);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PASS = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [GW-1:0]           ptr_q, ptr_d;
    logic [GW-1:0]           grant_q, grant_d;
    logic [WEIGHT_WIDTH-1:0] credit_q, credit_d;

    logic [DATA_WIDTH-1:0]   m_tdata_q, m_tdata_d;
    logic [KEEP_WIDTH-1:0]   m_tkeep_q, m_tkeep_d;
    logic                    m_tvalid_q, m_tvalid_d;
    logic                    m_tlast_q, m_tlast_d;
    logic [DEST_WIDTH-1:0]   m_tdest_q, m_tdest_d;
    logic [USER_WIDTH-1:0]   m_tuser_q, m_tuser_d;

    logic [CNT_WIDTH-1:0]    cnt_q [NUM_STREAMS];
    logic [CNT_WIDTH-1:0]    cnt_d [NUM_STREAMS];

    logic [NUM_STREAMS-1:0]  cand;
    logic                    hit;
    logic [GW-1:0]           winner;
    logic [WEIGHT_WIDTH-1:0] win_weight;

    logic [DATA_WIDTH-1:0]   src_tdata;
    logic [KEEP_WIDTH-1:0]   src_tkeep;
    logic [USER_WIDTH-1:0]   src_tuser;
    logic                    src_tvalid;
    logic                    src_tlast;
    logic                    src_rdy;
    logic                    src_hs;
    logic [NUM_STREAMS-1:0]  src_tready;

    // Round-robin search starting at the pointer; first enabled, valid source wins.
    always_comb begin
        int idx;
        idx    = 0;
        cand   = axis.s_axis_tvalid & i_enable;
        hit    = 1'b0;
        winner = '0;
        for (int k = 0; k < NUM_STREAMS; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_STREAMS) begin
                idx = idx - NUM_STREAMS;
            end
            if (!hit && cand[idx]) begin
                hit    = 1'b1;
                winner = GW'(idx);
            end
        end
        win_weight = i_weight[winner*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    end

    // Select the granted source's beat.
    always_comb begin
        src_tdata  = axis.s_axis_tdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
        src_tkeep  = axis.s_axis_tkeep[grant_q*KEEP_WIDTH +: KEEP_WIDTH];
        src_tuser  = axis.s_axis_tuser[grant_q*USER_WIDTH +: USER_WIDTH];
        src_tvalid = axis.s_axis_tvalid[grant_q];
        src_tlast  = axis.s_axis_tlast[grant_q];
    end

    // Arbitration FSM, source handshake and output register next-state.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        credit_d   = credit_q;
        src_rdy    = 1'b0;
        src_hs     = 1'b0;
        src_tready = '0;
        m_tdata_d  = m_tdata_q;
        m_tkeep_d  = m_tkeep_q;
        m_tvalid_d = m_tvalid_q;
        m_tlast_d  = m_tlast_q;
        m_tdest_d  = m_tdest_q;
        m_tuser_d  = m_tuser_q;

        case (state_q)
            ST_IDLE: begin
                if (hit) begin
                    grant_d  = winner;
                    // A zero weight still earns one packet per turn.
                    credit_d = (win_weight == '0) ? WEIGHT_WIDTH'(1) : win_weight;
                    state_d  = ST_PASS;
                end
            end
            ST_PASS: begin
                src_rdy             = ~m_tvalid_q | axis.m_axis_tready;
                src_tready[grant_q] = src_rdy;
                src_hs              = src_tvalid & src_rdy;
                // Enable and credit are only looked at on the packet boundary.
                if (src_hs && src_tlast) begin
                    credit_d = credit_q - WEIGHT_WIDTH'(1);
                    if (credit_q > WEIGHT_WIDTH'(1) && src_tvalid && i_enable[grant_q]) begin
                        state_d = ST_PASS;
                    end else begin
                        state_d = ST_IDLE;
                        ptr_d   = (grant_q == GW'(NUM_STREAMS - 1)) ? '0 : grant_q + GW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (src_hs) begin
            m_tdata_d  = src_tdata;
            m_tkeep_d  = src_tkeep;
            m_tuser_d  = src_tuser;
            m_tlast_d  = src_tlast;
            m_tdest_d  = DEST_WIDTH'(grant_q);
            m_tvalid_d = 1'b1;
        end else if (axis.m_axis_tready) begin
            m_tvalid_d = 1'b0;
        end
    end

    // Saturating per-stream packet counters; a clear wins over a same-cycle increment.
    always_comb begin
        for (int i = 0; i < NUM_STREAMS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (i_cnt_clear[i]) begin
                cnt_d[i] = '0;
            end else if (src_hs && src_tlast && grant_q == GW'(i) && cnt_q[i] != '1) begin
                cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
            end
        end
    end

    // State, pointer, credit and output register flops.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            grant_q    <= '0;
            credit_q   <= '0;
            m_tdata_q  <= '0;
            m_tkeep_q  <= '0;
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
            m_tdest_q  <= '0;
            m_tuser_q  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            credit_q   <= credit_d;
            m_tdata_q  <= m_tdata_d;
            m_tkeep_q  <= m_tkeep_d;
            m_tvalid_q <= m_tvalid_d;
            m_tlast_q  <= m_tlast_d;
            m_tdest_q  <= m_tdest_d;
            m_tuser_q  <= m_tuser_d;
        end
    end

    // Counter flops.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_STREAMS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_STREAMS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Flatten counters for the regfile.
    always_comb begin
        o_pkt_count = '0;
        for (int i = 0; i < NUM_STREAMS; i++) begin
            o_pkt_count[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
        end
    end

    assign axis.s_axis_tready = src_tready;
    assign axis.m_axis_tdata  = m_tdata_q;
    assign axis.m_axis_tkeep  = m_tkeep_q;
    assign axis.m_axis_tvalid = m_tvalid_q;
    assign axis.m_axis_tlast  = m_tlast_q;
    assign axis.m_axis_tdest  = m_tdest_q;
    assign axis.m_axis_tuser  = m_tuser_q;
    assign o_grant            = grant_q;
    assign o_busy             = (state_q == ST_PASS);

endmodule

// File: tb/tb_tcp_stream_arb.sv
// Directed bench for the weighted round-robin stream arbiter.
// Latency: sources and sink modelled cycle by cycle; outputs sampled on the falling edge.
// Backpressure: sink ready driven per scenario.
module tb_tcp_stream_arb;
    localparam int N      = 8;
    localparam int DW     = 8;
    localparam int KW     = 1;
    localparam int DEST_W = 8;
    localparam int UW     = 1;
    localparam int WW     = 4;
    localparam int CW     = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    tcp_stream_arb_if #(.NUM_STREAMS(N), .DATA_WIDTH(DW), .KEEP_WIDTH(KW),
                        .DEST_WIDTH(DEST_W), .USER_WIDTH(UW)) bus ();

    logic [N-1:0]    enable;
    logic [N-1:0]    cnt_clear;
    logic [N*WW-1:0] weight;
    logic [N*CW-1:0] pkt_count;
    logic [2:0]      grant;
    logic            busy;

    tcp_stream_arb #(.NUM_STREAMS(N), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .DEST_WIDTH(DEST_W),
                     .USER_WIDTH(UW), .WEIGHT_WIDTH(WW), .CNT_WIDTH(CW)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .axis        (bus.slave),
        .i_enable    (enable),
        .i_weight    (weight),
        .i_cnt_clear (cnt_clear),
        .o_pkt_count (pkt_count),
        .o_grant     (grant),
        .o_busy      (busy)
    );

    // Source model state
    int         src_npkts [N];
    int         src_len   [N];
    int         src_beat  [N];
    int         src_pno   [N];
    logic [7:0] src_base  [N];

    // Output beat log
    logic [7:0] log_data [$];
    int         log_dest [$];
    logic       log_last [$];
    int         log_cyc  [$];

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    task automatic drive_src();
        for (int i = 0; i < N; i++) begin
            bus.s_axis_tvalid[i]         = (src_npkts[i] > 0);
            bus.s_axis_tdata[i*DW +: DW] = src_base[i] + 8'(src_pno[i] * src_len[i] + src_beat[i]);
            bus.s_axis_tkeep[i]          = 1'b1;
            bus.s_axis_tlast[i]          = (src_beat[i] == src_len[i] - 1);
            bus.s_axis_tuser[i]          = (src_beat[i] == 0);
        end
    endtask

    task automatic clear_src();
        for (int i = 0; i < N; i++) begin
            src_npkts[i] = 0;
            src_len[i]   = 1;
            src_beat[i]  = 0;
            src_pno[i]   = 0;
            src_base[i]  = 8'h00;
        end
        drive_src();
    endtask

    task automatic clear_log();
        log_data.delete();
        log_dest.delete();
        log_last.delete();
        log_cyc.delete();
    endtask

    // One clock: sample handshakes, cross the rising edge, advance sources, settle at the falling edge.
    task automatic step();
        logic [N-1:0] shs;
        logic         ohs;
        #1;
        shs = bus.s_axis_tvalid & bus.s_axis_tready;
        ohs = bus.m_axis_tvalid & bus.m_axis_tready;
        if (ohs) begin
            log_data.push_back(bus.m_axis_tdata);
            log_dest.push_back(int'(bus.m_axis_tdest));
            log_last.push_back(bus.m_axis_tlast);
            log_cyc.push_back(cyc);
        end
        @(posedge clk);
        cyc++;
        #1;
        for (int i = 0; i < N; i++) begin
            if (shs[i]) begin
                if (src_beat[i] == src_len[i] - 1) begin
                    src_beat[i]  = 0;
                    src_npkts[i] = src_npkts[i] - 1;
                    src_pno[i]   = src_pno[i] + 1;
                end else begin
                    src_beat[i] = src_beat[i] + 1;
                end
            end
        end
        drive_src();
        @(negedge clk);
    endtask

    function automatic logic srcs_done();
        logic d;
        d = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (src_npkts[i] > 0) d = 1'b0;
        end
        return d;
    endfunction

    task automatic wait_done(input int max_cyc, input string name);
        int n;
        n = 0;
        while (!(srcs_done() && !busy && !bus.m_axis_tvalid) && n < max_cyc) begin
            step();
            n++;
        end
        checks++;
        if (!(srcs_done() && !busy && !bus.m_axis_tvalid)) begin
            errors++;
            $display("FAIL %s_timeout: still busy=%0b m_tvalid=%0b after %0d cycles, required idle", name, busy, bus.m_axis_tvalid, max_cyc);
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        clear_src();
        clear_log();
        bus.m_axis_tready = 1'b1;
        enable    = '1;
        weight    = {N{4'h1}};
        cnt_clear = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.m_axis_tvalid !== 1'b0 || bus.m_axis_tdata !== 8'h00 || bus.m_axis_tdest !== 8'h00 || bus.m_axis_tlast !== 1'b0) begin
            errors++;
            $display("FAIL reset_out: got vld=%0b data=%h dest=%h last=%0b, required all 0", bus.m_axis_tvalid, bus.m_axis_tdata, bus.m_axis_tdest, bus.m_axis_tlast);
        end
        checks++;
        if (busy !== 1'b0 || grant !== 3'd0) begin
            errors++;
            $display("FAIL reset_state: got busy=%0b grant=%0d, required 0 0", busy, grant);
        end
        checks++;
        if (bus.s_axis_tready !== 8'h00) begin
            errors++;
            $display("FAIL reset_tready: got %b, required 00000000", bus.s_axis_tready);
        end
        checks++;
        if (pkt_count !== '0) begin
            errors++;
            $display("FAIL reset_count: got %h, required 0", pkt_count);
        end
    endtask

    task automatic test_single();
        int start;
        do_reset();
        src_npkts[3] = 1;
        src_len[3]   = 4;
        src_base[3]  = 8'h10;
        start        = cyc;
        drive_src();
        step();
        checks++;
        if (busy !== 1'b1 || grant !== 3'd3 || bus.m_axis_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL single_bubble: got busy=%0b grant=%0d vld=%0b, required 1 3 0", busy, grant, bus.m_axis_tvalid);
        end
        wait_done(50, "single");
        checks++;
        if (log_data.size() != 4) begin
            errors++;
            $display("FAIL single_beats: got %0d beats, required 4", log_data.size());
        end
        for (int k = 0; k < 4 && k < log_data.size(); k++) begin
            checks++;
            if (log_data[k] !== 8'(8'h10 + k) || log_dest[k] != 3 || log_last[k] !== (k == 3) || log_cyc[k] != start + 2 + k) begin
                errors++;
                $display("FAIL single_beat%0d: got data=%h dest=%0d last=%0b cyc=%0d, required data=%h dest=3 last=%0b cyc=%0d",
                         k, log_data[k], log_dest[k], log_last[k], log_cyc[k], 8'(8'h10 + k), (k == 3), start + 2 + k);
            end
        end
        checks++;
        if (pkt_count[3*CW +: CW] !== 4'd1) begin
            errors++;
            $display("FAIL single_count: got %0d, required 1", pkt_count[3*CW +: CW]);
        end
    endtask

    task automatic test_round_robin();
        int order [$];
        int exp_order [6] = '{0, 2, 5, 0, 2, 5};
        int srcs [3] = '{0, 2, 5};
        do_reset();
        foreach (srcs[j]) begin
            src_npkts[srcs[j]] = 2;
            src_len[srcs[j]]   = 2;
            src_base[srcs[j]]  = 8'(srcs[j] * 32);
        end
        drive_src();
        wait_done(100, "rr");
        foreach (log_last[k]) if (log_last[k]) order.push_back(log_dest[k]);
        checks++;
        if (order.size() != 6) begin
            errors++;
            $display("FAIL rr_npkts: got %0d packets, required 6", order.size());
        end
        for (int k = 0; k < 6 && k < order.size(); k++) begin
            checks++;
            if (order[k] != exp_order[k]) begin
                errors++;
                $display("FAIL rr_order%0d: got stream %0d, required %0d", k, order[k], exp_order[k]);
            end
        end
        foreach (srcs[j]) begin
            checks++;
            if (pkt_count[srcs[j]*CW +: CW] !== 4'd2) begin
                errors++;
                $display("FAIL rr_count%0d: got %0d, required 2", srcs[j], pkt_count[srcs[j]*CW +: CW]);
            end
        end
    endtask

    task automatic test_weighted(input logic [3:0] w4);
        int order [$];
        int exp_order [8] = '{1, 1, 1, 4, 1, 1, 1, 4};
        do_reset();
        weight[1*WW +: WW] = 4'd3;
        weight[4*WW +: WW] = w4;
        src_npkts[1] = 6;
        src_len[1]   = 2;
        src_base[1]  = 8'h20;
        src_npkts[4] = 2;
        src_len[4]   = 2;
        src_base[4]  = 8'h80;
        drive_src();
        wait_done(100, "wrr");
        foreach (log_last[k]) if (log_last[k]) order.push_back(log_dest[k]);
        checks++;
        if (order.size() != 8) begin
            errors++;
            $display("FAIL wrr_npkts_w%0d: got %0d packets, required 8", w4, order.size());
        end
        for (int k = 0; k < 8 && k < order.size(); k++) begin
            checks++;
            if (order[k] != exp_order[k]) begin
                errors++;
                $display("FAIL wrr_order%0d_w%0d: got stream %0d, required %0d", k, w4, order[k], exp_order[k]);
            end
        end
        checks++;
        if (log_cyc.size() < 6 || log_cyc[5] - log_cyc[0] != 5) begin
            errors++;
            $display("FAIL wrr_b2b_w%0d: got span %0d over first 6 beats, required 5", w4, (log_cyc.size() < 6) ? -1 : log_cyc[5] - log_cyc[0]);
        end
    endtask

    task automatic test_backpressure();
        int n;
        do_reset();
        src_npkts[6] = 1;
        src_len[6]   = 4;
        src_base[6]  = 8'h60;
        drive_src();
        n = 0;
        while (!bus.m_axis_tvalid && n < 10) begin
            step();
            n++;
        end
        step();
        bus.m_axis_tready = 1'b0;
        for (int s = 0; s < 2; s++) begin
            step();
            checks++;
            if (bus.m_axis_tvalid !== 1'b1 || bus.m_axis_tdata !== 8'h61 || bus.m_axis_tlast !== 1'b0 ||
                bus.m_axis_tdest !== 8'd6 || bus.s_axis_tready[6] !== 1'b0) begin
                errors++;
                $display("FAIL bp_stall%0d: got vld=%0b data=%h last=%0b dest=%0d src_rdy=%0b, required 1 61 0 6 0",
                         s, bus.m_axis_tvalid, bus.m_axis_tdata, bus.m_axis_tlast, bus.m_axis_tdest, bus.s_axis_tready[6]);
            end
        end
        bus.m_axis_tready = 1'b1;
        wait_done(50, "bp");
        checks++;
        if (log_data.size() != 4) begin
            errors++;
            $display("FAIL bp_beats: got %0d beats, required 4", log_data.size());
        end
        for (int k = 0; k < 4 && k < log_data.size(); k++) begin
            checks++;
            if (log_data[k] !== 8'(8'h60 + k) || log_last[k] !== (k == 3)) begin
                errors++;
                $display("FAIL bp_beat%0d: got data=%h last=%0b, required data=%h last=%0b", k, log_data[k], log_last[k], 8'(8'h60 + k), (k == 3));
            end
        end
    endtask

    task automatic test_enable_drop();
        int n;
        do_reset();
        weight[2*WW +: WW] = 4'd3;
        src_npkts[2] = 3;
        src_len[2]   = 5;
        src_base[2]  = 8'h40;
        drive_src();
        n = 0;
        while (src_beat[2] != 2 && n < 20) begin
            step();
            n++;
        end
        enable[2] = 1'b0;
        repeat (20) step();
        checks++;
        if (log_data.size() != 5) begin
            errors++;
            $display("FAIL en_beats: got %0d beats, required 5", log_data.size());
        end
        for (int k = 0; k < 5 && k < log_data.size(); k++) begin
            checks++;
            if (log_data[k] !== 8'(8'h40 + k) || log_last[k] !== (k == 4)) begin
                errors++;
                $display("FAIL en_beat%0d: got data=%h last=%0b, required data=%h last=%0b", k, log_data[k], log_last[k], 8'(8'h40 + k), (k == 4));
            end
        end
        checks++;
        if (busy !== 1'b0 || bus.s_axis_tready[2] !== 1'b0 || pkt_count[2*CW +: CW] !== 4'd1) begin
            errors++;
            $display("FAIL en_regrant: got busy=%0b src_rdy=%0b count=%0d, required 0 0 1", busy, bus.s_axis_tready[2], pkt_count[2*CW +: CW]);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        src_npkts[7] = 14;
        src_len[7]   = 1;
        src_base[7]  = 8'h70;
        drive_src();
        wait_done(200, "sat_a");
        checks++;
        if (pkt_count[7*CW +: CW] !== 4'd14) begin
            errors++;
            $display("FAIL sat_preset: got %0d, required 14", pkt_count[7*CW +: CW]);
        end
        src_npkts[7] = 3;
        drive_src();
        wait_done(50, "sat_b");
        checks++;
        if (pkt_count[7*CW +: CW] !== 4'hF) begin
            errors++;
            $display("FAIL sat_hold: got %0d, required 15", pkt_count[7*CW +: CW]);
        end
    endtask

    task automatic test_clear();
        int  n;
        logic hit;
        do_reset();
        src_npkts[0] = 1;
        src_len[0]   = 2;
        drive_src();
        wait_done(20, "clr_a");
        checks++;
        if (pkt_count[0 +: CW] !== 4'd1) begin
            errors++;
            $display("FAIL clr_pre: got %0d, required 1", pkt_count[0 +: CW]);
        end
        src_npkts[0] = 1;
        drive_src();
        n   = 0;
        hit = 1'b0;
        while (!hit && n < 20) begin
            if (bus.s_axis_tvalid[0] && bus.s_axis_tready[0] && bus.s_axis_tlast[0]) begin
                cnt_clear[0] = 1'b1;
                step();
                cnt_clear[0] = 1'b0;
                hit = 1'b1;
            end else begin
                step();
            end
            n++;
        end
        checks++;
        if (!hit || pkt_count[0 +: CW] !== 4'd0) begin
            errors++;
            $display("FAIL clr_coincident: got tlast_seen=%0b count=%0d, required 1 0", hit, pkt_count[0 +: CW]);
        end
        wait_done(20, "clr_b");
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        src_npkts[5] = 1;
        src_len[5]   = 1;
        src_base[5]  = 8'h50;
        drive_src();
        wait_done(20, "rm_a");
        clear_log();
        src_npkts[5] = 1;
        src_len[5]   = 6;
        src_pno[5]   = 0;
        drive_src();
        n = 0;
        while (log_data.size() < 2 && n < 20) begin
            step();
            n++;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.m_axis_tvalid !== 1'b0 || busy !== 1'b0 || pkt_count[5*CW +: CW] !== 4'd0 || bus.s_axis_tready[5] !== 1'b0) begin
            errors++;
            $display("FAIL rm_flush: got vld=%0b busy=%0b count=%0d src_rdy=%0b, required 0 0 0 0",
                     bus.m_axis_tvalid, busy, pkt_count[5*CW +: CW], bus.s_axis_tready[5]);
        end
        clear_src();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        checks++;
        if (busy !== 1'b0 || grant !== 3'd0 || bus.m_axis_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL rm_release: got busy=%0b grant=%0d vld=%0b, required 0 0 0", busy, grant, bus.m_axis_tvalid);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.m_axis_tready = 1'b1;
        enable    = '1;
        weight    = {N{4'h1}};
        cnt_clear = '0;
        clear_src();
        #2;
        test_reset();
        test_single();
        test_round_robin();
        test_weighted(4'd1);
        test_weighted(4'd0);
        test_backpressure();
        test_enable_drop();
        test_saturate();
        test_clear();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tcp_stream_arb.md
Name: tcp_stream_arb

Overview:
- Parametrised successor to the fixed 8-stream RX arbitration path of the TCP block.
- Packet-granular weighted round-robin arbiter merging NUM_STREAMS AXI-Stream sources into one stream toward the s2m DMA.
- Per-stream enable and weight; the source index is tagged onto m_axis_tdest.
- Registered output stage and saturating per-stream packet counters for the regfile.

Parameters:
- NUM_STREAMS, 8: number of input streams, 2..32.
- DATA_WIDTH, 8: tdata width.
- KEEP_WIDTH, (DATA_WIDTH+7)/8: tkeep width (derived).
- DEST_WIDTH, 8: tdest width; must be >= $clog2(NUM_STREAMS).
- USER_WIDTH, 1: tuser width.
- WEIGHT_WIDTH, 4: width of each per-stream weight (packets per turn).
- CNT_WIDTH, 16: width of each per-stream packet counter.

Ports:
Interface: one clock; reset is asynchronous and active-low.
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- s_axis_tdata  in  NUM_STREAMS*DATA_WIDTH  flattened source data; stream i at [i*DATA_WIDTH +: DATA_WIDTH].
- s_axis_tkeep  in  NUM_STREAMS*KEEP_WIDTH  source keep.
- s_axis_tvalid  in  NUM_STREAMS  source valid.
- s_axis_tready  out  NUM_STREAMS  source ready.
- s_axis_tlast  in  NUM_STREAMS  source last.
- s_axis_tuser  in  NUM_STREAMS*USER_WIDTH  source user.
- m_axis_tdata  out  DATA_WIDTH  merged data.
- m_axis_tkeep  out  KEEP_WIDTH  merged keep.
- m_axis_tvalid  out  1  merged valid.
- m_axis_tready  in  1  merged ready.
- m_axis_tlast  out  1  merged last.
- m_axis_tdest  out  DEST_WIDTH  zero-extended index of the source stream.
- m_axis_tuser  out  USER_WIDTH  merged user.
- i_enable  in  NUM_STREAMS  per-stream arbitration enable.
- i_weight  in  NUM_STREAMS*WEIGHT_WIDTH  packets per turn; 0 is treated as 1.
- i_cnt_clear  in  NUM_STREAMS  per-stream counter clear pulse.
- o_pkt_count  out  NUM_STREAMS*CNT_WIDTH  forwarded-packet counts.
- o_grant  out  $clog2(NUM_STREAMS)  currently granted stream.
- o_busy  out  1  high in PASS.

Behaviour:
- Reset values: all outputs 0; state IDLE; rr pointer 0; credit 0.
- State IDLE:
  - Candidate set = s_axis_tvalid & i_enable.
  - Search round-robin starting at the pointer; first candidate found wins.
  - On a hit, next cycle: o_grant = winner, credit = max(weight,1), state PASS.
  - No hit: stay in IDLE.
  - Arbitration costs 1 bubble cycle per grant.
- State PASS:
  - s_axis_tready[g] = (~m_axis_tvalid | m_axis_tready); all other tready bits are 0.
  - Output register loads on source handshake: data, keep, last, user, and tdest = g.
  - Output register clears m_axis_tvalid when m_axis_tready && no new load.
  - Input-to-output latency: 1 cycle; full throughput of 1 beat/cycle.
- On source handshake with tlast (packet accepted into the output register):
  - credit decrements.
  - If credit-1 > 0, s_axis_tvalid[g], and i_enable[g] are all true: stay in PASS on g (back-to-back, no bubble).
  - Otherwise: pointer = (g+1) mod NUM_STREAMS, state IDLE.
- Enable change:
  - i_enable[g] dropping mid-packet does not abort; the packet completes.
  - The enable is checked only at packet boundaries.
- Source stall:
  - A source deasserting tvalid mid-packet holds the grant indefinitely; no timeout.
- Output backpressure:
  - m_axis_tready low holds the output register.
  - tdata/tkeep/tlast/tuser/tdest stay stable while m_axis_tvalid && !m_axis_tready.
- Counters:
  - o_pkt_count[i] increments when a beat with tlast from stream i is accepted.
  - Counters saturate at all-ones.
  - i_cnt_clear[i] has priority over a simultaneous increment; the result is 0.
- Wrap-around: the pointer wraps from NUM_STREAMS-1 to 0; the search wraps modulo NUM_STREAMS.
- Single-beat packets (tlast on the first beat) are legal and consume 1 credit.
- Reset mid-packet: the output register is flushed, m_axis_tvalid = 0, the partial packet is lost, and the counters return to 0.

Test Plan:
- Single stream 3 holds a 4-beat packet 0x10..0x13, weight 1, m_axis_tready=1 -> 1 bubble cycle, then 4 consecutive output beats with tdest=3; tlast on 0x13; o_pkt_count[3]=1.
- Streams 0, 2 and 5 continuously valid with 2-beat packets, weights all 1 -> grant order 0,2,5,0,2,5; each stream's count = 2 after 6 packets.
- Stream 1 weight 3, stream 4 weight 1, both always valid -> packet order 1,1,1,4,1,1,1,4; weight 0 on stream 4 behaves identically to weight 1.
- Mid-packet m_axis_tready toggles 1,0,0,1 -> no beat lost or duplicated; outputs stable during the stall; s_axis_tready[g] low while the output register is full and stalled.
- i_enable[2] dropped during beat 2 of a 5-beat packet -> all 5 beats forwarded; stream 2 is not re-granted afterwards while still valid.
- Edge cases:
  - Counter preset to 0xFFFE plus 3 packets -> stays at 0xFFFF.
  - i_cnt_clear coincident with tlast -> count 0.
  - i_rst_n asserted mid-packet -> m_axis_tvalid=0 immediately; IDLE on release.
